// File: rtl/m10k_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : m10k_port_arbiter
// Purpose : Round-robin two-port arbiter with fairness-bounded lock in front
//           of one 256x8 registered-read M10K.
//           Optional macro M10K_ARB_RDATA_REG_EN adds a read-data output stage.
// Revision: 1.0
// ============================================================================
module m10k_port_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req0_valid,
  input  logic              i_req0_we,
  input  logic              i_req0_lock,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [DATA_W-1:0] i_req0_wdata,
  output logic              o_req0_ready,
  output logic              o_rd0_valid,
  output logic [DATA_W-1:0] o_rd0_data,
  input  logic              i_req1_valid,
  input  logic              i_req1_we,
  input  logic              i_req1_lock,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [DATA_W-1:0] i_req1_wdata,
  output logic              o_req1_ready,
  output logic              o_rd1_valid,
  output logic [DATA_W-1:0] o_rd1_data,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_write_address,
  output logic [ADDR_W-1:0] o_mem_read_address,
  output logic [DATA_W-1:0] o_mem_d,
  input  logic [DATA_W-1:0] i_mem_q
);

  localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_rr;
  logic [7:0]        r_lock_cnt;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_acc;
  logic              w_id;
  logic              w_we;
  logic              w_lock;
  logic              w_other_v;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_own_acc;
  logic [7:0]        w_cnt_inc;
  logic              w_limit;

  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_wa;
  logic [ADDR_W-1:0] r_mem_ra;
  logic [DATA_W-1:0] r_mem_d;

  logic              r_p1_v;
  logic              r_p1_id;
  logic              r_p2_v;
  logic              r_p2_id;
  logic              r_rd0_valid;
  logic              r_rd1_valid;
  logic [DATA_W-1:0] r_rd0_data;
  logic [DATA_W-1:0] r_rd1_data;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      ST_OWN0: w_gnt0 = i_req0_valid;
      ST_OWN1: w_gnt1 = i_req1_valid;
      default: begin
        w_gnt0 = i_req0_valid & (~i_req1_valid | ~r_rr);
        w_gnt1 = i_req1_valid & (~i_req0_valid |  r_rr);
      end
    endcase
  end

  assign w_acc     = w_gnt0 | w_gnt1;
  assign w_id      = w_gnt1;
  assign w_we      = w_id ? i_req1_we    : i_req0_we;
  assign w_lock    = w_id ? i_req1_lock  : i_req0_lock;
  assign w_addr    = w_id ? i_req1_addr  : i_req0_addr;
  assign w_wdata   = w_id ? i_req1_wdata : i_req0_wdata;
  assign w_other_v = w_id ? i_req0_valid : i_req1_valid;
  // An accept counts toward the fairness limit once it is part of a burst.
  assign w_own_acc = w_lock | (r_state == (w_id ? ST_OWN1 : ST_OWN0));
  assign w_cnt_inc = r_lock_cnt + 8'd1;
  assign w_limit   = w_own_acc & w_other_v & (w_cnt_inc == LOCK_LIMIT);

  assign o_req0_ready = w_gnt0;
  assign o_req1_ready = w_gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rr       <= 1'b0;
      r_lock_cnt <= 8'd0;
    end else if (w_acc) begin
      r_rr <= ~w_id;
      if (w_limit) begin
        r_state    <= ST_IDLE;
        r_lock_cnt <= 8'd0;
      end else if (w_lock) begin
        r_state <= w_id ? ST_OWN1 : ST_OWN0;
        if (w_other_v) r_lock_cnt <= w_cnt_inc;
      end else begin
        r_state    <= ST_IDLE;
        r_lock_cnt <= 8'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we <= 1'b0;
      r_mem_wa <= '0;
      r_mem_ra <= '0;
      r_mem_d  <= '0;
    end else if (w_acc) begin
      r_mem_we <= w_we;
      r_mem_wa <= w_addr;
      r_mem_ra <= w_addr;
      if (w_we) r_mem_d <= w_wdata;
    end else begin
      r_mem_we <= 1'b0;
    end
  end

  assign o_mem_we            = r_mem_we;
  assign o_mem_write_address = r_mem_wa;
  assign o_mem_read_address  = r_mem_ra;
  assign o_mem_d             = r_mem_d;

  // p1 aligns with the registered address, p2 with mem_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_v  <= 1'b0;
      r_p1_id <= 1'b0;
      r_p2_v  <= 1'b0;
      r_p2_id <= 1'b0;
    end else begin
      r_p1_v  <= w_acc & ~w_we;
      r_p1_id <= w_id;
      r_p2_v  <= r_p1_v;
      r_p2_id <= r_p1_id;
    end
  end

`ifdef M10K_ARB_RDATA_REG_EN
  logic              r_s_v0;
  logic              r_s_v1;
  logic [DATA_W-1:0] r_s_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_v0      <= 1'b0;
      r_s_v1      <= 1'b0;
      r_s_data    <= '0;
      r_rd0_valid <= 1'b0;
      r_rd1_valid <= 1'b0;
      r_rd0_data  <= '0;
      r_rd1_data  <= '0;
    end else begin
      r_s_v0      <= r_p2_v & ~r_p2_id;
      r_s_v1      <= r_p2_v &  r_p2_id;
      r_s_data    <= i_mem_q;
      r_rd0_valid <= r_s_v0;
      r_rd1_valid <= r_s_v1;
      if (r_s_v0) r_rd0_data <= r_s_data;
      if (r_s_v1) r_rd1_data <= r_s_data;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd0_valid <= 1'b0;
      r_rd1_valid <= 1'b0;
      r_rd0_data  <= '0;
      r_rd1_data  <= '0;
    end else begin
      r_rd0_valid <= r_p2_v & ~r_p2_id;
      r_rd1_valid <= r_p2_v &  r_p2_id;
      if (r_p2_v & ~r_p2_id) r_rd0_data <= i_mem_q;
      if (r_p2_v &  r_p2_id) r_rd1_data <= i_mem_q;
    end
  end
`endif

  assign o_rd0_valid = r_rd0_valid;
  assign o_rd1_valid = r_rd1_valid;
  assign o_rd0_data  = r_rd0_data;
  assign o_rd1_data  = r_rd1_data;

endmodule
`default_nettype wire

// File: tb/tb_m10k_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_m10k_port_arbiter
// Purpose : Randomized and directed bench for m10k_port_arbiter against a
//           transaction-level model with an M10K behavioural memory.
// Revision: 1.0
// ============================================================================
module tb_m10k_port_arbiter;
  localparam int MAX_LOCK = 16;
`ifdef M10K_ARB_RDATA_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       tv  [2];
  logic       twe [2];
  logic       tlk [2];
  logic [7:0] ta  [2];
  logic [7:0] twd [2];

  logic       o_req0_ready, o_req1_ready;
  logic       o_rd0_valid, o_rd1_valid;
  logic [7:0] o_rd0_data, o_rd1_data;
  logic       o_mem_we;
  logic [7:0] o_mem_write_address, o_mem_read_address, o_mem_d;
  logic [7:0] m10k_q;
  logic [7:0] m10k [256];

  m10k_port_arbiter #(.DATA_W(8), .ADDR_W(8), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req0_valid(tv[0]), .i_req0_we(twe[0]), .i_req0_lock(tlk[0]),
    .i_req0_addr(ta[0]), .i_req0_wdata(twd[0]),
    .o_req0_ready(o_req0_ready), .o_rd0_valid(o_rd0_valid), .o_rd0_data(o_rd0_data),
    .i_req1_valid(tv[1]), .i_req1_we(twe[1]), .i_req1_lock(tlk[1]),
    .i_req1_addr(ta[1]), .i_req1_wdata(twd[1]),
    .o_req1_ready(o_req1_ready), .o_rd1_valid(o_rd1_valid), .o_rd1_data(o_rd1_data),
    .o_mem_we(o_mem_we), .o_mem_write_address(o_mem_write_address),
    .o_mem_read_address(o_mem_read_address), .o_mem_d(o_mem_d),
    .i_mem_q(m10k_q)
  );

  // Single-clock M10K: registered read, old data on collision.
  always @(posedge clk) begin
    if (o_mem_we) m10k[o_mem_write_address] <= o_mem_d;
    m10k_q <= m10k[o_mem_read_address];
  end

  // Transaction-level reference
  typedef struct { int due; int id; logic [7:0] data; } ret_t;
  ret_t       rq[$];
  int         gnt_q[$];
  logic [7:0] ref_mem [256];
  logic [7:0] last_d [2];
  int         owner, fav, cnt, edge_cnt;
  logic       exp_we;
  logic [7:0] exp_addr, exp_d;
  int         checks, failures;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; fav = 0; cnt = 0;
    rq.delete();
    last_d[0] = 8'h00; last_d[1] = 8'h00;
    exp_we = 1'b0; exp_addr = 8'h00; exp_d = 8'h00;
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      tv[k] = 1'b0; twe[k] = 1'b0; tlk[k] = 1'b0; ta[k] = 8'h00; twd[k] = 8'h00;
    end
  endtask

  task automatic set_req(input int k, input logic v, input logic we, input logic lk,
                         input logic [7:0] a, input logic [7:0] d);
    tv[k] = v; twe[k] = we; tlk[k] = lk; ta[k] = a; twd[k] = d;
  endtask

  function automatic int gq(input int i);
    return (i < gnt_q.size()) ? gnt_q[i] : -1;
  endfunction

  // One clock: inputs already applied while clk is low.
  task automatic step(output int g);
    logic r[2];
    logic rv[2];
    int k, o;
    #1;
    if (owner >= 0) begin
      r[0] = (owner == 0) && tv[0];
      r[1] = (owner == 1) && tv[1];
    end else if (tv[0] && tv[1]) begin
      r[0] = (fav == 0);
      r[1] = (fav == 1);
    end else begin
      r[0] = tv[0];
      r[1] = tv[1];
    end
    chk("ready0", o_req0_ready, r[0]);
    chk("ready1", o_req1_ready, r[1]);
    @(posedge clk);
    edge_cnt++;
    g = -1;
    if (r[0] || r[1]) begin
      k = r[1] ? 1 : 0;
      o = 1 - k;
      g = k;
      gnt_q.push_back(k);
      if (twe[k]) ref_mem[ta[k]] = twd[k];
      else rq.push_back('{edge_cnt + LAT, k, ref_mem[ta[k]]});
      exp_we = twe[k];
      exp_addr = ta[k];
      if (twe[k]) exp_d = twd[k];
      fav = o;
      if ((owner == k || tlk[k]) && tv[o]) cnt++;
      if (cnt == MAX_LOCK) begin
        owner = -1; cnt = 0;
      end else if (tlk[k]) begin
        owner = k;
      end else begin
        owner = -1; cnt = 0;
      end
    end else begin
      exp_we = 1'b0;
    end
    @(negedge clk);
    chk("mem_we", o_mem_we, exp_we);
    chk("mem_waddr", o_mem_write_address, exp_addr);
    chk("mem_raddr", o_mem_read_address, exp_addr);
    if (exp_we) chk("mem_d", o_mem_d, exp_d);
    rv[0] = 1'b0; rv[1] = 1'b0;
    if (rq.size() > 0 && rq[0].due == edge_cnt) begin
      rv[rq[0].id] = 1'b1;
      last_d[rq[0].id] = rq[0].data;
      void'(rq.pop_front());
    end
    chk("rd0_valid", o_rd0_valid, rv[0]);
    chk("rd1_valid", o_rd1_valid, rv[1]);
    chk("rd0_data", o_rd0_data, last_d[0]);
    chk("rd1_data", o_rd1_data, last_d[1]);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready0", o_req0_ready, 0);
    chk("rst_ready1", o_req1_ready, 0);
    chk("rst_rd0_valid", o_rd0_valid, 0);
    chk("rst_rd1_valid", o_rd1_valid, 0);
    chk("rst_rd0_data", o_rd0_data, 0);
    chk("rst_rd1_data", o_rd1_data, 0);
    chk("rst_mem_we", o_mem_we, 0);
    chk("rst_mem_wa", o_mem_write_address, 0);
    chk("rst_mem_ra", o_mem_read_address, 0);
    chk("rst_mem_d", o_mem_d, 0);
  endtask

  initial begin
    int g, n1, t3_start, i, run1;
    checks = 0; failures = 0; edge_cnt = 0;
    for (int a = 0; a < 256; a++) begin
      m10k[a] = 8'h00;
      ref_mem[a] = 8'h00;
    end
    idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;

    // req0 fills addrs 0..15 with 0x01, req1 idle
    for (int a = 0; a < 16; a++) begin
      set_req(0, 1'b1, 1'b1, 1'b0, 8'(a), 8'h01);
      step(g);
      chk("t1_grant", g, 0);
    end
    idle();
    step(g);

    // both read every cycle, alternating grants
    for (int c = 0; c < 8; c++) begin
      set_req(0, 1'b1, 1'b0, 1'b0, 8'd3, 8'h00);
      set_req(1, 1'b1, 1'b0, 1'b0, 8'd5, 8'h00);
      step(g);
      chk("t2_alternate", g, (c % 2 == 0) ? 1 : 0);
    end
    idle();
    repeat (LAT + 1) step(g);
    chk("t2_rd0_data", o_rd0_data, 8'h01);
    chk("t2_rd1_data", o_rd1_data, 8'h01);

    // write then immediately read the same address from the other side
    set_req(0, 1'b1, 1'b1, 1'b0, 8'd9, 8'h7F);
    step(g);
    idle();
    set_req(1, 1'b1, 1'b0, 1'b0, 8'd9, 8'h00);
    step(g);
    chk("t4_read_grant", g, 1);
    idle();
    repeat (LAT + 1) step(g);
    chk("t4_rd1_data", o_rd1_data, 8'h7F);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++)
        set_req(k, ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
                ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 31)), 8'($urandom));
      step(g);
    end
    idle();
    repeat (4) step(g);

    // reset one cycle after a read accept
    set_req(0, 1'b1, 1'b0, 1'b0, 8'd3, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 8'd5, 8'h00);
    step(g);
    chk("t5_read_accepted", (g >= 0), 1);
    idle();
    step(g);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("t5_rd0_quiet", o_rd0_valid, 0);
      chk("t5_rd1_quiet", o_rd1_valid, 0);
    end
    rst_n = 1'b1;
    repeat (LAT + 1) step(g);
    set_req(0, 1'b1, 1'b0, 1'b0, 8'd3, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 8'd5, 8'h00);
    step(g);
    chk("t5_favour0", g, 0);

    // req1 locked burst against a continuously valid req0
    t3_start = gnt_q.size();
    n1 = 0;
    for (int c = 0; c < 200 && n1 < 40; c++) begin
      set_req(0, 1'b1, 1'b0, 1'b0, 8'd3, 8'h00);
      set_req(1, 1'b1, 1'b0, 1'b1, 8'(n1), 8'h00);
      step(g);
      if (g == 1) n1++;
    end
    chk("t3_bound", n1, 40);
    i = t3_start;
    run1 = 0;
    while (gq(i) == 1) begin
      run1++;
      i++;
    end
    chk("t3_first_run", run1, 16);
    chk("t3_then_req0", gq(i), 0);
    chk("t3_resume_req1", gq(i + 1), 1);
    idle();
    repeat (LAT + 2) step(g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
